// File: rtl/watch_apb_slave.sv
// APB3 responder for the stopwatch: turns CMD writes into throttled one-cycle pulses and serves time/lap reads.
// Optional build macro WATCH_IRQ_EN adds oIRQ (lap-overwrite flag) and the IRQ register at 0x38.
module watch_apb_slave #(
  parameter int CMD_GAP = 4,
  parameter int ADDR_W  = 8
) (
  input  logic              iCLK,
  input  logic              iRESET,
  input  logic              iPSEL,
  input  logic              iPENABLE,
  input  logic              iPWRITE,
  input  logic [ADDR_W-1:0] iPADDR,
  input  logic [31:0]       iPWDATA,
  output logic [31:0]       oPRDATA,
  output logic              oPREADY,
  output logic              oPSLVERR,
  output logic              oWATCH_START,
  output logic              oWATCH_STOP,
  output logic              oWATCH_RESET,
  output logic              oWATCH_STORE,
`ifdef WATCH_IRQ_EN
  output logic              oIRQ,
`endif
  input  logic              iCLKGEN_RUN,
  input  logic [31:0]       iCURR_TIME,
  input  logic [31:0]       iTIME_LAP0,
  input  logic [31:0]       iTIME_LAP1,
  input  logic [31:0]       iTIME_LAP2,
  input  logic [31:0]       iTIME_LAP3,
  input  logic [31:0]       iTIME_LAP4,
  input  logic [31:0]       iTIME_LAP5,
  input  logic [31:0]       iTIME_LAP6,
  input  logic [31:0]       iTIME_LAP7,
  input  logic [31:0]       iTIME_LAP8,
  input  logic [31:0]       iTIME_LAP9
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, HOLD} stateT;

  localparam logic [ADDR_W-3:0] W_CMD    = (ADDR_W-2)'(0);
  localparam logic [ADDR_W-3:0] W_STATUS = (ADDR_W-2)'(1);
  localparam logic [ADDR_W-3:0] W_TIME   = (ADDR_W-2)'(2);
  localparam logic [ADDR_W-3:0] W_LAP0   = (ADDR_W-2)'(4);
  localparam logic [ADDR_W-3:0] W_LAP9   = (ADDR_W-2)'(13);
  localparam logic [3:0]        GAP_LOAD = 4'(CMD_GAP - 1);

  stateT             state, nextState;
  logic [3:0]        pulseVec;
  logic [3:0]        holdoff;
  logic [3:0]        lapCnt;
  logic [31:0]       rdBuf;
  logic [31:0]       readMux;
  logic              readOk, writeOk, xferErr;
  logic              ready, issue, holdoffBusy;
  logic              isCmd, validCmd, isLap;
  logic [ADDR_W-3:0] wordAddr;
  logic [3:0]        lapSel;
  logic              unusedBits;
`ifdef WATCH_IRQ_EN
  localparam logic [ADDR_W-3:0] W_IRQ = (ADDR_W-2)'(14);
  logic irq, irqClear;
`endif

  assign wordAddr    = iPADDR[ADDR_W-1:2];
  assign lapSel      = 4'(wordAddr - W_LAP0);
  assign isLap       = (wordAddr >= W_LAP0) && (wordAddr <= W_LAP9);
  assign isCmd       = iPWRITE && (wordAddr == W_CMD);
  assign validCmd    = isCmd && $onehot(iPWDATA[3:0]);
  assign holdoffBusy = (holdoff != 4'd0) || (pulseVec != 4'd0);
  assign unusedBits  = ^{iPWDATA[31:4], iPADDR[1:0]};

  // Read decode; unmapped reads return zero and flag an error.
  always_comb begin
    readMux = '0;
    readOk  = 1'b1;
    if (wordAddr == W_CMD)
      readMux = '0;
    else if (wordAddr == W_STATUS)
      readMux = {23'd0, holdoffBusy, lapCnt, 3'd0, iCLKGEN_RUN};
    else if (wordAddr == W_TIME)
      readMux = iCURR_TIME;
    else if (isLap) begin
      case (lapSel)
        4'd0:    readMux = iTIME_LAP0;
        4'd1:    readMux = iTIME_LAP1;
        4'd2:    readMux = iTIME_LAP2;
        4'd3:    readMux = iTIME_LAP3;
        4'd4:    readMux = iTIME_LAP4;
        4'd5:    readMux = iTIME_LAP5;
        4'd6:    readMux = iTIME_LAP6;
        4'd7:    readMux = iTIME_LAP7;
        4'd8:    readMux = iTIME_LAP8;
        4'd9:    readMux = iTIME_LAP9;
        default: readMux = '0;
      endcase
    end
`ifdef WATCH_IRQ_EN
    else if (wordAddr == W_IRQ)
      readMux = {31'd0, irq};
`endif
    else
      readOk = 1'b0;
  end

`ifdef WATCH_IRQ_EN
  assign writeOk  = validCmd || (iPWRITE && (wordAddr == W_IRQ));
  assign irqClear = ready && iPWRITE && (wordAddr == W_IRQ) && iPWDATA[0];
  assign oIRQ     = irq;
`else
  assign writeOk  = validCmd;
`endif
  assign xferErr = iPWRITE ? !writeOk : !readOk;

  always_ff @(posedge iCLK) begin
    if (iRESET) state <= IDLE;
    else        state <= nextState;
  end

  // Invalid commands finish immediately with an error; only real commands wait out the hold-off.
  always_comb begin
    nextState = state;
    ready     = 1'b0;
    case (state)
      IDLE:   if (iPSEL && !iPENABLE) nextState = SETUP;
      SETUP:  nextState = ACCESS;
      ACCESS: begin
        if (validCmd && holdoffBusy) nextState = HOLD;
        else begin
          ready     = 1'b1;
          nextState = (iPSEL && !iPENABLE) ? SETUP : IDLE;
        end
      end
      HOLD: begin
        if (!iPSEL) nextState = IDLE;
        else if (!holdoffBusy) begin
          ready     = 1'b1;
          nextState = (iPSEL && !iPENABLE) ? SETUP : IDLE;
        end
      end
      default: nextState = IDLE;
    endcase
  end

  assign issue    = ready && validCmd;
  assign oPREADY  = ready;
  assign oPSLVERR = ready && xferErr;
  assign oPRDATA  = (ready && !iPWRITE) ? rdBuf : 32'd0;

  assign oWATCH_START = pulseVec[0];
  assign oWATCH_STOP  = pulseVec[1];
  assign oWATCH_RESET = pulseVec[2];
  assign oWATCH_STORE = pulseVec[3];

  // Snapshot at the end of SETUP keeps a multi-field time read coherent.
  always_ff @(posedge iCLK) begin
    if (iRESET) begin
      pulseVec <= '0;
      holdoff  <= '0;
      lapCnt   <= '0;
      rdBuf    <= '0;
    end else begin
      if (state == SETUP) rdBuf <= readMux;
      pulseVec <= issue ? iPWDATA[3:0] : 4'd0;
      if (pulseVec != 4'd0)    holdoff <= GAP_LOAD;
      else if (holdoff != 4'd0) holdoff <= holdoff - 4'd1;
      if (pulseVec[3] && (lapCnt != 4'd10)) lapCnt <= lapCnt + 4'd1;
      else if (pulseVec[2])                 lapCnt <= 4'd0;
    end
  end

`ifdef WATCH_IRQ_EN
  always_ff @(posedge iCLK) begin
    if (iRESET)                              irq <= 1'b0;
    else if (pulseVec[3] && lapCnt == 4'd10) irq <= 1'b1;
    else if (irqClear)                       irq <= 1'b0;
  end
`endif

endmodule

// File: tb/tb_watch_apb_slave.sv
// Bench for watch_apb_slave: directed scenarios plus random APB traffic against a cycle-level reference model.
module tb_watch_apb_slave;
  localparam int CMD_GAP = 4;

  logic        iCLK = 1'b0;
  logic        iRESET = 1'b1;
  logic        iPSEL = 1'b0, iPENABLE = 1'b0, iPWRITE = 1'b0;
  logic [7:0]  iPADDR = '0;
  logic [31:0] iPWDATA = '0;
  logic [31:0] oPRDATA;
  logic        oPREADY, oPSLVERR;
  logic        oWATCH_START, oWATCH_STOP, oWATCH_RESET, oWATCH_STORE;
`ifdef WATCH_IRQ_EN
  logic        oIRQ;
`endif
  logic        iCLKGEN_RUN = 1'b0;
  logic [31:0] iCURR_TIME = '0;
  logic [31:0] lapT [10];

  watch_apb_slave #(.CMD_GAP(CMD_GAP), .ADDR_W(8)) dut (
    .iCLK(iCLK), .iRESET(iRESET), .iPSEL(iPSEL), .iPENABLE(iPENABLE),
    .iPWRITE(iPWRITE), .iPADDR(iPADDR), .iPWDATA(iPWDATA),
    .oPRDATA(oPRDATA), .oPREADY(oPREADY), .oPSLVERR(oPSLVERR),
    .oWATCH_START(oWATCH_START), .oWATCH_STOP(oWATCH_STOP),
    .oWATCH_RESET(oWATCH_RESET), .oWATCH_STORE(oWATCH_STORE),
`ifdef WATCH_IRQ_EN
    .oIRQ(oIRQ),
`endif
    .iCLKGEN_RUN(iCLKGEN_RUN), .iCURR_TIME(iCURR_TIME),
    .iTIME_LAP0(lapT[0]), .iTIME_LAP1(lapT[1]), .iTIME_LAP2(lapT[2]),
    .iTIME_LAP3(lapT[3]), .iTIME_LAP4(lapT[4]), .iTIME_LAP5(lapT[5]),
    .iTIME_LAP6(lapT[6]), .iTIME_LAP7(lapT[7]), .iTIME_LAP8(lapT[8]),
    .iTIME_LAP9(lapT[9])
  );

  always #5 iCLK = ~iCLK;

  int cyc = 0;
  always @(posedge iCLK) cyc <= cyc + 1;

  int nCompared = 0;
  int nMismatched = 0;

  typedef struct {logic [3:0] kind; int at;} pulseT;
  pulseT expQ[$];

  // Reference model state: lap count, irq flag, cycle of the most recent pulse.
  int lapModel = 0;
  bit irqModel = 1'b0;
  int lastPulse = -100;
  bit monOn = 1'b0;
  bit changeTime = 1'b0;
  logic [31:0] timeAfterSetup = '0;
  logic [3:0] obsPulse, expPulse;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
    nCompared++;
    if (got !== want) begin
      nMismatched++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  // Every pulse the DUT raises must be one the model predicted, in the predicted cycle.
  always @(negedge iCLK) begin
    if (monOn && !iRESET) begin
      obsPulse = {oWATCH_STORE, oWATCH_RESET, oWATCH_STOP, oWATCH_START};
      expPulse = 4'd0;
      if (expQ.size() > 0 && expQ[0].at == cyc) begin
        expPulse = expQ[0].kind;
        void'(expQ.pop_front());
      end
      if (obsPulse !== 4'd0 || expPulse != 4'd0)
        checkOutput("pulse", 32'(obsPulse), 32'(expPulse));
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic apbXfer(input logic wr, input logic [7:0] addr, input logic [31:0] wdata,
                         output logic [31:0] rdata, output logic err, output int waits,
                         output int setupCyc, output int doneCyc);
    @(negedge iCLK);
    iPSEL = 1'b1; iPENABLE = 1'b0; iPWRITE = wr; iPADDR = addr; iPWDATA = wdata;
    @(negedge iCLK);
    iPENABLE = 1'b1;
    setupCyc = cyc;
    waits = 0;
    if (changeTime) begin
      @(posedge iCLK);
      #1 iCURR_TIME = timeAfterSetup;
    end
    do begin
      @(negedge iCLK);
      waits++;
    end while (!oPREADY && waits < 64);
    rdata = oPRDATA;
    err = oPSLVERR;
    doneCyc = cyc;
    @(posedge iCLK);
    #1;
    iPSEL = 1'b0; iPENABLE = 1'b0;
  endtask

  task automatic applyStimulus(input logic wr, input logic [7:0] addr, input logic [31:0] wdata);
    logic [31:0] rd, expRd;
    logic er, expEr;
    int w, s, c, expW, word, earliest;
    logic [31:0] timeSnap;
    logic [3:0] cmd;
    bit validCmd, busy;
    word = int'(addr >> 2);
    cmd = wdata[3:0];
    validCmd = wr && (word == 0) && ($countones(cmd) == 1);
    timeSnap = iCURR_TIME;
    apbXfer(wr, addr, wdata, rd, er, w, s, c);
    busy = (s >= lastPulse) && (s < lastPulse + CMD_GAP);
    expRd = 32'd0;
    expEr = 1'b0;
    if (!wr) begin
      if (word == 0)       expRd = 32'd0;
      else if (word == 1)  expRd = {23'd0, busy, 4'(lapModel), 3'd0, iCLKGEN_RUN};
      else if (word == 2)  expRd = timeSnap;
      else if (word >= 4 && word <= 13) expRd = lapT[word-4];
`ifdef WATCH_IRQ_EN
      else if (word == 14) expRd = {31'd0, irqModel};
`endif
      else expEr = 1'b1;
    end else begin
`ifdef WATCH_IRQ_EN
      expEr = !(validCmd || word == 14);
`else
      expEr = !validCmd;
`endif
    end
    earliest = lastPulse + CMD_GAP;
    expW = (validCmd && earliest > s + 1) ? earliest - (s + 1) + 1 : 1;
    checkOutput("waits", 32'(w), 32'(expW));
    checkOutput("rdata", rd, expRd);
    checkOutput("slverr", {31'd0, er}, {31'd0, expEr});
    if (validCmd && w < 64) begin
      expQ.push_back('{kind: cmd, at: c + 1});
      lastPulse = c + 1;
      if (cmd == 4'b1000) begin
        if (lapModel == 10) irqModel = 1'b1;
        else lapModel++;
      end else if (cmd == 4'b0100) lapModel = 0;
    end
`ifdef WATCH_IRQ_EN
    if (wr && word == 14 && wdata[0]) irqModel = 1'b0;
`endif
  endtask

  task automatic checkQuiet(input string tag);
    checkOutput({tag, "_prdata"}, oPRDATA, 32'd0);
    checkOutput({tag, "_ctrl"},
                {26'd0, oPREADY, oPSLVERR, oWATCH_STORE, oWATCH_RESET, oWATCH_STOP, oWATCH_START},
                32'd0);
`ifdef WATCH_IRQ_EN
    checkOutput({tag, "_irq"}, {31'd0, oIRQ}, 32'd0);
`endif
  endtask

  task automatic modelReset();
    lapModel = 0;
    irqModel = 1'b0;
    lastPulse = -100;
    expQ.delete();
  endtask

  initial begin
    logic [3:0] v;
    int kind;
    for (int i = 0; i < 10; i++) lapT[i] = 32'h0;

    // Reset: outputs idle throughout.
    iRESET = 1'b1;
    @(posedge iCLK);
    repeat (3) begin
      @(negedge iCLK);
      checkQuiet("reset");
    end
    iRESET = 1'b0;
    modelReset();
    monOn = 1'b1;
    iCLKGEN_RUN = 1'b0;
    applyStimulus(1'b0, 8'h04, 32'h0);

    // START then an immediate STOP that must wait out the hold-off.
    applyStimulus(1'b1, 8'h00, 32'h1);
    applyStimulus(1'b1, 8'h00, 32'h2);

    // Malformed commands and a write to a read-only register.
    applyStimulus(1'b1, 8'h00, 32'h3);
    applyStimulus(1'b1, 8'h00, 32'h0);
    applyStimulus(1'b1, 8'h08, 32'h5);

    // Time snapshot is taken at the end of SETUP.
    iCURR_TIME = 32'h0000_0163;
    timeAfterSetup = 32'h0000_0164;
    changeTime = 1'b1;
    applyStimulus(1'b0, 8'h08, 32'h0);
    changeTime = 1'b0;
    lapT[3] = 32'h0102_0304;
    applyStimulus(1'b0, 8'h1C, 32'h0);

    // Lap counter saturation, lap-overwrite flag, then RESET clears the count.
    for (int i = 0; i < 11; i++) begin
      applyStimulus(1'b1, 8'h00, 32'h8);
      if (i >= 9) applyStimulus(1'b0, 8'h04, 32'h0);
    end
`ifdef WATCH_IRQ_EN
    repeat (2) @(negedge iCLK);
    checkOutput("irqSet", {31'd0, oIRQ}, {31'd0, irqModel});
    applyStimulus(1'b0, 8'h38, 32'h0);
    applyStimulus(1'b1, 8'h38, 32'h1);
    @(negedge iCLK);
    checkOutput("irqClear", {31'd0, oIRQ}, {31'd0, irqModel});
`endif
    applyStimulus(1'b1, 8'h00, 32'h4);
    applyStimulus(1'b0, 8'h04, 32'h0);

    // Reset while a STOP sits in HOLD: the command is dropped and counters clear.
    applyStimulus(1'b1, 8'h00, 32'h8);
    applyStimulus(1'b1, 8'h00, 32'h1);
    @(negedge iCLK);
    iPSEL = 1'b1; iPENABLE = 1'b0; iPWRITE = 1'b1; iPADDR = 8'h00; iPWDATA = 32'h2;
    @(negedge iCLK);
    iPENABLE = 1'b1;
    repeat (2) begin
      @(negedge iCLK);
      checkOutput("holdReady", {31'd0, oPREADY}, 32'd0);
    end
    iRESET = 1'b1;
    repeat (2) @(negedge iCLK);
    checkQuiet("midReset");
    iPSEL = 1'b0; iPENABLE = 1'b0; iRESET = 1'b0;
    modelReset();
    repeat (6) @(negedge iCLK);
    iCLKGEN_RUN = 1'b0;
    applyStimulus(1'b0, 8'h04, 32'h0);
    applyStimulus(1'b0, 8'h3C, 32'h0);

    // Random traffic.
    for (int n = 0; n < 200; n++) begin
      iCLKGEN_RUN = 1'($urandom_range(0, 1));
      iCURR_TIME = $urandom;
      for (int i = 0; i < 10; i++) lapT[i] = $urandom;
      kind = $urandom_range(0, 9);
      if (kind <= 2) begin
        applyStimulus(1'b1, 8'(2'($urandom_range(0, 3))),
                      ($urandom & 32'hFFFF_FFF0) | (32'h1 << $urandom_range(0, 3)));
      end else if (kind == 3) begin
        do v = 4'($urandom_range(0, 15)); while ($countones(v) == 1);
        applyStimulus(1'b1, 8'h00, ($urandom & 32'hFFFF_FFF0) | {28'd0, v});
      end else if (kind <= 7) begin
        applyStimulus(1'b0, 8'({6'($urandom_range(0, 14)), 2'($urandom_range(0, 3))}), $urandom);
      end else if (kind == 8) begin
        applyStimulus(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), $urandom);
      end else begin
        applyStimulus(1'b1, 8'({6'($urandom_range(1, 14)), 2'b00}), $urandom);
      end
      repeat ($urandom_range(0, 2)) @(negedge iCLK);
    end

    repeat (8) @(negedge iCLK);
    checkOutput("pulseDrain", 32'(expQ.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule

// File: doc/watch_apb_slave.md
Name: watch_apb_slave

Overview:
APB3 responder that sits between the bus and the stopwatch time generator. It decodes bus writes into single-cycle command pulses (START/STOP/RESET/STORE) for the time generator and returns its current time and lap registers on bus reads. Command writes are throttled by a hold-off counter, so back-to-back commands never land inside the generator's transient states (LAP_STORE, RESET).

Parameters:
CMD_GAP, 4, minimum clocks between two issued command pulses (1..15)
ADDR_W, 8, APB address width

Ports:
iCLK  input  1  clock
iRESET  input  1  synchronous reset, active-high
iPSEL  input  1  APB select
iPENABLE  input  1  APB enable
iPWRITE  input  1  1=write, 0=read
iPADDR  input  ADDR_W  byte address; bits[1:0] ignored
iPWDATA  input  32  write data
oPRDATA  output  32  read data
oPREADY  output  1  transfer complete
oPSLVERR  output  1  transfer error, valid when oPREADY=1
oWATCH_START  output  1  one-cycle start pulse
oWATCH_STOP  output  1  one-cycle stop pulse
oWATCH_RESET  output  1  one-cycle reset pulse
oWATCH_STORE  output  1  one-cycle lap-store pulse
iCLKGEN_RUN  input  1  generator running flag
iCURR_TIME  input  32  {hour,min,sec,sub_sec}
iTIME_LAP0..iTIME_LAP9  input  32 each  stored lap times

Behaviour:
- Reset: all outputs 0, FSM=IDLE, hold-off counter=0, lap_cnt=0, read buffer=0.
- Register map:
  - 0x00 CMD (W): bit0 START, bit1 STOP, bit2 RESET, bit3 STORE. Reads return 0 with no error.
  - 0x04 STATUS (R): [0]=iCLKGEN_RUN, [7:4]=lap_cnt, [8]=holdoff_busy, others 0.
  - 0x08 CURR_TIME (R).
  - 0x10+4*n LAPn (R), n=0..9 (0x10..0x34).
- FSM states:
  - IDLE: goes to SETUP on iPSEL & !iPENABLE.
  - SETUP: always goes to ACCESS. At the end of SETUP, read data is captured into the read buffer (snapshot, so a CURR_TIME read is coherent).
  - ACCESS: reads and non-CMD writes complete in the first ACCESS cycle. A CMD write completes in the first ACCESS cycle if hold-off=0; otherwise it goes to HOLD.
  - HOLD: oPREADY=0 until hold-off=0, then oPREADY=1 and return to IDLE.
  - After completion: IDLE, or SETUP if the next setup phase is presented.
- oPREADY is combinational: 1 only in the completing cycle, 0 otherwise. oPRDATA = read buffer when oPREADY=1 & read; otherwise 0.
- Errors (oPSLVERR=1 with oPREADY, no side effect): unmapped address; write to a read-only address; CMD write with zero bits set or more than one of bits[3:0] set. Bits[31:4] are ignored.
- Command pulses:
  - The selected pulse asserts exactly one cycle, in the cycle after the completing ACCESS/HOLD cycle.
  - On the pulse cycle, hold-off loads CMD_GAP-1, then decrements once per cycle down to 0. holdoff_busy = (hold-off != 0) or pulse pending.
- lap_cnt: +1 on each STORE pulse, saturates at 10. Cleared on a RESET pulse.
- Simultaneous events: none possible (one command per transfer).
- iRESET mid-transfer: the FSM aborts to IDLE, a pending pulse is dropped, and the counters clear.
- iPSEL deasserted while in HOLD: treated as a protocol violation. Return to IDLE and drop the command.

Optional Feature:
WATCH_IRQ_EN:
- Defined:
  - Adds output oIRQ (1 bit, reset 0).
  - oIRQ is set by a STORE pulse issued while lap_cnt==10 (lap overwrite) and stays high until cleared.
  - Register 0x38 IRQ: read [0]=oIRQ. Writing 1 to bit0 clears oIRQ.
  - If a set and a clear occur in the same cycle, set wins.
- Undefined: no oIRQ port; 0x38 is unmapped (PSLVERR).

Test Plan:
1. Assert iRESET 3 cycles, then read 0x04 with iCLKGEN_RUN=0 -> all outputs 0 during reset; PRDATA=0x00000000, PSLVERR=0.
2. Write 0x00=0x1 -> PREADY in first ACCESS cycle, oWATCH_START high exactly 1 cycle after. Then immediately write 0x00=0x2 (CMD_GAP=4) -> PREADY held low until 4 cycles after the START pulse, then oWATCH_STOP pulses once.
3. Write 0x00=0x3 and 0x00=0x0 -> PSLVERR=1, PREADY=1, no pulses. Write 0x08 -> PSLVERR=1.
4. Read 0x08 with iCURR_TIME=0x00000163 in SETUP, changing to 0x00000164 in ACCESS -> PRDATA=0x00000163. Read 0x1C with iTIME_LAP3=0x01020304 -> 0x01020304.
5. Issue 11 STORE writes -> STATUS[7:4]=0xA after the 10th and still 0xA after the 11th. With WATCH_IRQ_EN, oIRQ=1 after the 11th; write 0x38=0x1 -> oIRQ=0. A RESET command then gives STATUS[7:4]=0.
6. Assert iRESET during HOLD of a pending STOP write -> no oWATCH_STOP pulse, STATUS=0 afterwards. Read 0x3C -> PSLVERR=1, PRDATA=0.
